// File: rtl/simple_cpu.sv
// Single-cycle 8-bit processor core: 8-entry register file, ALU, branch unit and a
// 256-byte data memory. Instruction memory is external and read combinationally at PC_OUT.

module simple_cpu_regfile #(
  parameter int NUM_REGS = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr_a,
  input  logic [2:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);

  logic [7:0] reg_array [NUM_REGS];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) reg_array[i] <= '0;
    end else if (we) begin
      reg_array[waddr] <= wdata;
    end
  end

  assign rdata_a = reg_array[raddr_a];
  assign rdata_b = reg_array[raddr_b];

endmodule

module simple_cpu_data_mem #(
  parameter int DMEM_DEPTH = 256
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] memory_array [DMEM_DEPTH];

  // Every byte is a flop so that reset can clear the whole memory at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DMEM_DEPTH; i++) memory_array[i] <= '0;
    end else if (we) begin
      memory_array[addr] <= wdata;
    end
  end

  assign rdata = memory_array[addr];

endmodule

module simple_cpu #(
  parameter int DMEM_DEPTH = 256,
  parameter int NUM_REGS   = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC_OUT,
  input  logic [31:0] INSTRUCTION
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;
  localparam logic [7:0] OP_BNE   = 8'h0C;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] pc_next;

  logic [7:0] opcode;
  logic [7:0] offset;
  logic [7:0] imm;
  logic [2:0] rd;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic       unused_field_bits;

  logic [7:0] rs1_data;
  logic [7:0] rs2_data;
  logic       rf_we;
  logic [7:0] rf_wdata;

  logic       dm_we;
  logic [7:0] dm_addr;
  logic [7:0] dm_rdata;

  assign opcode = INSTRUCTION[31:24];
  assign offset = INSTRUCTION[23:16];
  assign rd     = INSTRUCTION[18:16];
  assign rs1    = INSTRUCTION[10:8];
  assign rs2    = INSTRUCTION[2:0];
  assign imm    = INSTRUCTION[7:0];
  assign unused_field_bits = ^INSTRUCTION[15:11];

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};

  // Register-indirect accesses use R[rs2] as the address; the rest use the immediate.
  assign dm_addr = ((opcode == OP_LWD) || (opcode == OP_SWD)) ? rs2_data : imm;

  simple_cpu_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .CLK     (CLK),
    .RESET   (RESET),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (rf_wdata),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (rs1_data),
    .rdata_b (rs2_data)
  );

  simple_cpu_data_mem #(.DMEM_DEPTH(DMEM_DEPTH)) u_data_mem (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (dm_we),
    .addr  (dm_addr),
    .wdata (rs1_data),
    .rdata (dm_rdata)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = '0;
    dm_we    = 1'b0;
    pc_next  = pc_plus4;
    case (opcode)
      OP_LOADI: begin rf_we = 1'b1; rf_wdata = imm;                 end
      OP_MOV:   begin rf_we = 1'b1; rf_wdata = rs2_data;            end
      OP_ADD:   begin rf_we = 1'b1; rf_wdata = rs1_data + rs2_data; end
      OP_SUB:   begin rf_we = 1'b1; rf_wdata = rs1_data - rs2_data; end
      OP_AND:   begin rf_we = 1'b1; rf_wdata = rs1_data & rs2_data; end
      OP_OR:    begin rf_we = 1'b1; rf_wdata = rs1_data | rs2_data; end
      OP_J:     pc_next = branch_target;
      OP_BEQ:   if (rs1_data == rs2_data) pc_next = branch_target;
      OP_BNE:   if (rs1_data != rs2_data) pc_next = branch_target;
      OP_LWD,
      OP_LWI:   begin rf_we = 1'b1; rf_wdata = dm_rdata; end
      OP_SWD,
      OP_SWI:   dm_we = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pc <= '0;
    else       pc <= pc_next;
  end

  assign PC_OUT = pc;

endmodule

// File: tb/tb_simple_cpu.sv
// Directed testbench for simple_cpu: the bench owns the instruction memory and
// checks PC, register file and data memory against hand-computed values.

module tb_simple_cpu;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC_OUT;
  logic [31:0] INSTRUCTION;

  logic [31:0] imem [64];
  int total;
  int bad;

  localparam logic [31:0] NOP = 32'hFF00_0000;

  simple_cpu dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC_OUT      (PC_OUT),
    .INSTRUCTION (INSTRUCTION)
  );

  assign INSTRUCTION = imem[PC_OUT[7:2]];

  // clock/reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  function automatic logic [31:0] rreg(input int idx);
    return {24'd0, dut.u_regfile.reg_array[idx]};
  endfunction

  function automatic logic [31:0] rmem(input int addr);
    return {24'd0, dut.u_data_mem.memory_array[addr]};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = NOP;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Leaves the bench at a falling edge with PC=0 and the first instruction pending.
  task automatic restart();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic branch_case(input string tag, input logic [31:0] br,
                             input logic [7:0] v, input logic [31:0] exp_pc);
    clear_imem();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'd3);
    imem[1] = ins(8'h00, 8'd2, 8'd0, v);
    imem[2] = br;
    restart();
    step(3);
    check(tag, PC_OUT, exp_pc);
    check({tag, "_r2"}, rreg(2), {24'd0, v});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RESET = 1'b1;
    clear_imem();

    // Reset and sequential fetch
    @(negedge CLK);
    check("reset_pc", PC_OUT, 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("reset_r%0d", i), rreg(i), 32'd0);
    check("reset_mem0", rmem(0), 32'd0);
    RESET = 1'b0;
    step(1); check("fetch_pc4", PC_OUT, 32'd4);
    step(1); check("fetch_pc8", PC_OUT, 32'd8);
    step(1); check("fetch_pc12", PC_OUT, 32'd12);

    // Arithmetic
    clear_imem();
    imem[0]  = ins(8'h00, 8'd1, 8'd0, 8'd5);
    imem[1]  = ins(8'h00, 8'd2, 8'd0, 8'd9);
    imem[2]  = ins(8'h02, 8'd3, 8'd1, 8'd2);
    imem[3]  = ins(8'h03, 8'd4, 8'd1, 8'd2);
    imem[4]  = ins(8'h04, 8'd5, 8'd1, 8'd2);
    imem[5]  = ins(8'h05, 8'd6, 8'd1, 8'd2);
    imem[6]  = ins(8'h00, 8'd7, 8'd0, 8'hFF);
    imem[7]  = ins(8'h00, 8'd2, 8'd0, 8'h02);
    imem[8]  = ins(8'h02, 8'd0, 8'd7, 8'd2);
    imem[9]  = ins(8'h01, 8'd1, 8'd0, 8'd6);
    restart();
    check("restart_pc", PC_OUT, 32'd0);
    step(3);
    check("add_fwd_r3", rreg(3), 32'h0E);
    step(7);
    check("add_r3", rreg(3), 32'h0E);
    check("sub_r4", rreg(4), 32'hFC);
    check("and_r5", rreg(5), 32'h01);
    check("or_r6", rreg(6), 32'h0D);
    check("add_wrap_r0", rreg(0), 32'h01);
    check("mov_r1", rreg(1), 32'h0D);
    check("arith_pc", PC_OUT, 32'd40);

    // Memory
    clear_imem();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h2A);
    imem[1] = ins(8'h0B, 8'd7, 8'd1, 8'h07);
    imem[2] = ins(8'h09, 8'd2, 8'd0, 8'h07);
    imem[3] = ins(8'h00, 8'd3, 8'd0, 8'd7);
    imem[4] = ins(8'h08, 8'd4, 8'd0, 8'd3);
    imem[5] = ins(8'h00, 8'd5, 8'd0, 8'h33);
    imem[6] = ins(8'h00, 8'd6, 8'd0, 8'h80);
    imem[7] = ins(8'h0A, 8'd7, 8'd5, 8'd6);
    restart();
    step(8);
    check("swi_mem7", rmem(7), 32'h2A);
    check("lwi_r2", rreg(2), 32'h2A);
    check("lwd_r4", rreg(4), 32'h2A);
    check("swd_mem80", rmem(8'h80), 32'h33);
    check("store_no_rd", rreg(7), 32'h00);
    check("mem_other", rmem(8'h2A), 32'h00);

    // Asynchronous reset between clock edges
    #2;
    RESET = 1'b1;
    #1;
    check("areset_pc", PC_OUT, 32'd0);
    check("areset_r1", rreg(1), 32'd0);
    check("areset_r4", rreg(4), 32'd0);
    check("areset_mem7", rmem(7), 32'd0);
    check("areset_mem80", rmem(8'h80), 32'd0);
    step(1);
    check("areset_hold_pc", PC_OUT, 32'd0);
    check("areset_hold_r1", rreg(1), 32'd0);
    RESET = 1'b0;
    step(1);
    check("rerun_pc4", PC_OUT, 32'd4);
    check("rerun_r1", rreg(1), 32'h2A);
    check("rerun_mem7_pre", rmem(7), 32'd0);
    step(1);
    check("rerun_mem7", rmem(7), 32'h2A);

    // Branches
    branch_case("beq_taken", ins(8'h07, 8'h02, 8'd1, 8'd2), 8'd3, 32'd20);
    branch_case("beq_not_taken", ins(8'h07, 8'h02, 8'd1, 8'd2), 8'd4, 32'd12);
    branch_case("bne_equal", ins(8'h0C, 8'h02, 8'd1, 8'd2), 8'd3, 32'd12);
    branch_case("bne_taken", ins(8'h0C, 8'h02, 8'd1, 8'd2), 8'd4, 32'd20);

    clear_imem();
    imem[4] = ins(8'h06, 8'hFE, 8'd0, 8'd0);
    restart();
    step(5);
    check("j_back_pc", PC_OUT, 32'd12);
    check("j_no_rd", rreg(6), 32'd0);
    step(2);
    check("j_loop_pc", PC_OUT, 32'd12);

    // Unlisted opcodes
    clear_imem();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h11);
    imem[1] = ins(8'hFF, 8'd1, 8'd1, 8'h22);
    imem[2] = ins(8'h0D, 8'd2, 8'd1, 8'h22);
    restart();
    step(2);
    check("nop_ff_pc", PC_OUT, 32'd8);
    check("nop_ff_r1", rreg(1), 32'h11);
    step(1);
    check("nop_0d_pc", PC_OUT, 32'd12);
    check("nop_0d_r2", rreg(2), 32'd0);
    check("nop_mem22", rmem(8'h22), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
